fp_from_int: RTL and testbench

FP_FROM_INT -- requirements
Module: fp_from_int

---
 rtl/fp_from_int.sv | 131 +++++++++++++
 tb/tb_fp_from_int.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_from_int.sv
// fp_from_int: converts a signed 32-bit integer into an IEEE-754 single-precision
// value. The magnitude is normalized one bit per cycle, then rounded to
// nearest-even in a single cycle. Zero takes a short path that never
// produces a negative zero.
module fp_from_int (
   input  logic        clk,
   input  logic        restart_n,
   input  logic        start,
   input  logic [31:0] N,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      ZERO  = 2'd3
   } state_t;

   state_t      state_r;
   logic        sign_r;
   logic [31:0] mag_r;
   logic [7:0]  exp_r;
   logic [31:0] result_r;
   logic        done_r;
   logic        busy_r;

   logic [31:0] abs_s;
   logic [22:0] mant_s;
   logic        guard_s;
   logic        sticky_s;
   logic        round_up_s;
   logic [23:0] mant_sum_s;
   logic [22:0] mant_rnd_s;
   logic [7:0]  exp_rnd_s;

   // Magnitude of the operand; -2^31 wraps to 0x80000000, which is exactly |N|.
   always_comb begin
      abs_s = N;
      if (N[31]) begin
         abs_s = (~N) + 32'd1;
      end else begin
         abs_s = N;
      end
   end

   // Round-to-nearest-even on the normalized magnitude, including mantissa overflow.
   always_comb begin
      mant_s     = mag_r[30:8];
      guard_s    = mag_r[7];
      sticky_s   = |mag_r[6:0];
      round_up_s = guard_s & (sticky_s | mant_s[0]);
      mant_sum_s = {1'b0, mant_s} + {23'd0, round_up_s};
      mant_rnd_s = mant_sum_s[22:0];
      exp_rnd_s  = exp_r;
      if (mant_sum_s[23]) begin
         mant_rnd_s = 23'd0;
         exp_rnd_s  = exp_r + 8'd1;
      end else begin
         mant_rnd_s = mant_sum_s[22:0];
         exp_rnd_s  = exp_r;
      end
   end

   // Conversion FSM with registered result, done pulse and busy flag.
   always_ff @(posedge clk or negedge restart_n) begin
      if (!restart_n) begin
         state_r  <= IDLE;
         sign_r   <= 1'b0;
         mag_r    <= 32'd0;
         exp_r    <= 8'd0;
         result_r <= 32'd0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  sign_r <= N[31];
                  mag_r  <= abs_s;
                  exp_r  <= 8'd158;
                  busy_r <= 1'b1;
                  if (N == 32'd0) begin
                     state_r <= ZERO;
                  end else begin
                     state_r <= NORM;
                  end
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            NORM: begin
               done_r <= 1'b0;
               busy_r <= 1'b1;
               if (mag_r[31]) begin
                  state_r <= ROUND;
               end else begin
                  mag_r <= {mag_r[30:0], 1'b0};
                  exp_r <= exp_r - 8'd1;
               end
            end
            ROUND: begin
               result_r <= {sign_r, exp_rnd_s, mant_rnd_s};
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            ZERO: begin
               result_r <= 32'd0;
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign result = result_r;
   assign done   = done_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_fp_from_int.sv
// Directed bench for fp_from_int: latency, rounding, zero path, handshake and reset.
module tb_fp_from_int;

   logic        clk;
   logic        restart_n;
   logic        start;
   logic [31:0] N;
   logic [31:0] result;
   logic        done;
   logic        busy;

   int n_cmp;
   int n_mis;

   fp_from_int dut (
      .clk       (clk),
      .restart_n (restart_n),
      .start     (start),
      .N         (N),
      .result    (result),
      .done      (done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one edge (edge 0) and wait for done; lat_o = -1 on timeout.
   // Must be called between clock edges.
   task automatic run_conv(input logic [31:0] n, input int budget,
                           output int lat_o, output logic [31:0] res_o);
      lat_o = -1;
      res_o = 32'hxxxxxxxx;
      start = 1'b1;
      N     = n;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int e = 1; e <= budget; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat_o = e;
            res_o = result;
            break;
         end
      end
   endtask

   task automatic test_reset;
      restart_n = 1'b0;
      start     = 1'b0;
      N         = 32'd0;
      #12;
      n_cmp++; if (result !== 32'd0) begin n_mis++; $display("FAIL reset_result got=%h want=00000000", result); end
      n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b want=0", busy); end
      @(negedge clk);
      restart_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_one;
      int lat;
      int busy_bad;
      lat = -1;
      busy_bad = 0;
      start = 1'b1;
      N     = 32'h00000001;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e <= 32 && busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            lat = e;
            break;
         end
      end
      n_cmp++; if (lat !== 33) begin n_mis++; $display("FAIL one_latency got=%0d want=33", lat); end
      n_cmp++; if (result !== 32'h3F800000) begin n_mis++; $display("FAIL one_result got=%h want=3f800000", result); end
      n_cmp++; if (busy_bad !== 0) begin n_mis++; $display("FAIL one_busy low_edges=%0d want=0", busy_bad); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL one_busy_at_done got=%b want=0", busy); end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL one_done_width got=%b want=0", done); end
   endtask

   task automatic test_values;
      logic [31:0] vn   [8];
      logic [31:0] vres [8];
      int          vlat [8];
      int          lat;
      logic [31:0] res;
      vn[0] = 32'h80000000; vres[0] = 32'hCF000000; vlat[0] = 2;
      vn[1] = 32'h7FFFFFFF; vres[1] = 32'h4F000000; vlat[1] = 3;
      vn[2] = 32'h01000001; vres[2] = 32'h4B800000; vlat[2] = 9;
      vn[3] = 32'h01000003; vres[3] = 32'h4B800002; vlat[3] = 9;
      vn[4] = 32'h00000000; vres[4] = 32'h00000000; vlat[4] = 1;
      vn[5] = 32'h00000005; vres[5] = 32'h40A00000; vlat[5] = 31;
      vn[6] = 32'hFFFFFFFB; vres[6] = 32'hC0A00000; vlat[6] = 31;
      vn[7] = 32'hFFFFFFFF; vres[7] = 32'hBF800000; vlat[7] = 33;
      for (int i = 0; i < 8; i++) begin
         run_conv(vn[i], 40, lat, res);
         n_cmp++; if (lat !== vlat[i]) begin n_mis++; $display("FAIL value_latency N=%h got=%0d want=%0d", vn[i], lat, vlat[i]); end
         n_cmp++; if (res !== vres[i]) begin n_mis++; $display("FAIL value_result N=%h got=%h want=%h", vn[i], res, vres[i]); end
      end
   endtask

   task automatic test_ignore_busy;
      int          dones;
      int          lat;
      logic [31:0] res;
      dones = 0;
      lat   = -1;
      res   = 32'd0;
      start = 1'b1;
      N     = 32'h00000001;
      @(posedge clk);
      #1;
      start = 1'b0;
      N     = 32'h00000002;
      for (int e = 1; e <= 45; e++) begin
         @(posedge clk);
         #1;
         if (e == 5) start = 1'b1;
         if (e == 6) start = 1'b0;
         if (done === 1'b1) begin
            dones++;
            lat = e;
            res = result;
         end
      end
      n_cmp++; if (dones !== 1) begin n_mis++; $display("FAIL busy_ignore_dones got=%0d want=1", dones); end
      n_cmp++; if (lat !== 33) begin n_mis++; $display("FAIL busy_ignore_latency got=%0d want=33", lat); end
      n_cmp++; if (res !== 32'h3F800000) begin n_mis++; $display("FAIL busy_ignore_result got=%h want=3f800000", res); end
   endtask

   task automatic test_back_to_back;
      int          dedge [4];
      logic [31:0] dres  [4];
      int          dones;
      int          want_edge [3];
      int          lat;
      logic [31:0] res;
      want_edge[0] = 27;
      want_edge[1] = 55;
      want_edge[2] = 83;
      dones = 0;
      start = 1'b1;
      N     = 32'h00000040;
      for (int e = 0; e <= 90; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 && dones < 4) begin
            dedge[dones] = e;
            dres[dones]  = result;
            dones++;
         end
      end
      start = 1'b0;
      n_cmp++; if (dones !== 3) begin n_mis++; $display("FAIL b2b_done_count got=%0d want=3", dones); end
      for (int i = 0; i < 3; i++) begin
         if (i < dones) begin
            n_cmp++; if (dedge[i] !== want_edge[i]) begin n_mis++; $display("FAIL b2b_edge[%0d] got=%0d want=%0d", i, dedge[i], want_edge[i]); end
            n_cmp++; if (dres[i] !== 32'h42800000) begin n_mis++; $display("FAIL b2b_result[%0d] got=%h want=42800000", i, dres[i]); end
         end else begin
            n_cmp++; n_mis++; $display("FAIL b2b_missing_done[%0d] got=none want=edge %0d", i, want_edge[i]);
         end
      end
      // drain the conversion accepted at edge 84
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = e;
            res = result;
            break;
         end
      end
      n_cmp++; if (lat !== 21) begin n_mis++; $display("FAIL b2b_drain_latency got=%0d want=21", lat); end
      // zero operand with start held: done on every other edge
      start = 1'b1;
      N     = 32'd0;
      for (int e = 0; e <= 7; e++) begin
         @(posedge clk);
         #1;
         n_cmp++; if (done !== e[0]) begin n_mis++; $display("FAIL b2b_zero_done edge=%0d got=%b want=%b", e, done, e[0]); end
      end
      start = 1'b0;
      n_cmp++; if (result !== 32'd0) begin n_mis++; $display("FAIL b2b_zero_result got=%h want=00000000", result); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midop;
      int          dones;
      int          lat;
      logic [31:0] res;
      start = 1'b1;
      N     = 32'h00000001;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
      end
      #1;
      restart_n = 1'b0;
      #1;
      n_cmp++; if (result !== 32'd0) begin n_mis++; $display("FAIL midop_reset_result got=%h want=00000000", result); end
      n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL midop_reset_done got=%b want=0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL midop_reset_busy got=%b want=0", busy); end
      @(negedge clk);
      @(negedge clk);
      restart_n = 1'b1;
      dones = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_mis++; $display("FAIL midop_no_done got=%0d want=0", dones); end
      run_conv(32'hFFFFFFFF, 40, lat, res);
      n_cmp++; if (res !== 32'hBF800000) begin n_mis++; $display("FAIL midop_after_result got=%h want=bf800000", res); end
      // start is accepted on the very first edge after reset release
      restart_n = 1'b0;
      @(negedge clk);
      restart_n = 1'b1;
      start     = 1'b1;
      N         = 32'h80000000;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = e;
            res = result;
            break;
         end
      end
      n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL first_edge_latency got=%0d want=2", lat); end
      n_cmp++; if (res !== 32'hCF000000) begin n_mis++; $display("FAIL first_edge_result got=%h want=cf000000", res); end
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      test_reset();
      test_one();
      test_values();
      test_ignore_busy();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
